// File: rtl/amp_pkg.sv
// Shared types for the duty level control stage.
// Debouncer state encoding and button index constants.
package amp_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } deb_state_t;

   localparam int BTN_DOWN = 0;
   localparam int BTN_UP   = 1;

endpackage

// File: rtl/duty_level_ctrl_if.sv
// Control-side bundle between panel/PWM and the duty level stage.
// master drives buttons/enable/period strobe, slave returns duty and leds.
interface duty_level_ctrl_if #(
   parameter int N = 4
);
   logic         ena;
   logic [1:0]   buttons;
   logic         pwm_step;
   logic [N-1:0] duty;
   logic [1:0]   leds;

   modport master (
      output ena,
      output buttons,
      output pwm_step,
      input  duty,
      input  leds
   );

   modport slave (
      input  ena,
      input  buttons,
      input  pwm_step,
      output duty,
      output leds
   );
endinterface

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchroniser, debounce FSM, 1-cycle press pulse.
// Optional hold-to-repeat pulses when DUTY_AUTOREPEAT_EN is defined.
module button_debounce
   import amp_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 12000,
   parameter int REPEAT_TICKS   = 3000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [1:0]   sync_ff;
   logic         s;
   deb_state_t   state;
   logic [CW-1:0] cnt;
   logic         press_q;

   assign s     = sync_ff[1];
   assign press = press_q;

   // bring the raw button into the clk domain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_ff <= 2'b00;
      else      sync_ff <= {sync_ff[0], btn};
   end

`ifdef DUTY_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] RLAST = RW'(REPEAT_TICKS - 1);

   logic [RW-1:0] rep;

   // debounce FSM with hold-to-repeat pulses while HELD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RELEASED;
         cnt     <= '0;
         rep     <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         unique case (state)
            RELEASED: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state   <= HELD;
                  cnt     <= '0;
                  rep     <= '0;
                  press_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= CW'(1);
                  rep   <= '0;
               end else if (rep == RLAST) begin
                  rep     <= '0;
                  press_q <= 1'b1;
               end else begin
                  rep <= rep + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end
`else
   // debounce FSM, one pulse per accepted press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RELEASED;
         cnt     <= '0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         unique case (state)
            RELEASED: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state   <= HELD;
                  cnt     <= '0;
                  press_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= CW'(1);
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end
`endif

endmodule

// File: rtl/duty_level_ctrl.sv
// Duty level control: debounced up/down buttons step a saturating level,
// handed to the PWM only on pwm_step. Optional macro: DUTY_AUTOREPEAT_EN.
module duty_level_ctrl
   import amp_pkg::*;
#(
   parameter int N              = 4,
   parameter int DEBOUNCE_TICKS = 12000,
   parameter int RESET_LEVEL    = 8,
   parameter int REPEAT_TICKS   = 3000000
) (
   input logic               clk,
   input logic               rst,
   duty_level_ctrl_if.slave  bus
);

   localparam logic [N-1:0] MAX_LVL = {N{1'b1}};
   localparam logic [N-1:0] RST_LVL = N'(RESET_LEVEL);

   if (RESET_LEVEL > (2**N) - 1 || RESET_LEVEL < 0 ||
       DEBOUNCE_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_cfg
      $error("duty_level_ctrl: illegal parameter set");
   end

   logic         press_up;
   logic         press_dn;
   logic [N-1:0] level;
   logic [N-1:0] duty_q;
   logic [1:0]   leds_q;
   logic         step_up;
   logic         step_dn;

   button_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
   ) u_deb_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.buttons[BTN_UP]),
      .press (press_up)
   );

   button_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
   ) u_deb_dn (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.buttons[BTN_DOWN]),
      .press (press_dn)
   );

   assign step_up = bus.ena & press_up & ~press_dn & (level != MAX_LVL);
   assign step_dn = bus.ena & press_dn & ~press_up & (level != '0);

   // saturating level; presses while disabled are dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         level <= RST_LVL;
      else if (step_up) level <= level + 1'b1;
      else if (step_dn) level <= level - 1'b1;
   end

   // duty shadow register, loaded only at PWM period start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              duty_q <= RST_LVL;
      else if (bus.pwm_step) duty_q <= bus.ena ? level : '0;
   end

   // status leds follow the level one cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) leds_q <= {RST_LVL == MAX_LVL, RST_LVL == '0};
      else      leds_q <= {level == MAX_LVL, level == '0};
   end

   assign bus.duty = duty_q;
   assign bus.leds = leds_q;

endmodule
